// File: rtl/sha256_digest_unloader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_digest_unloader_pkg : widths and unloader state shared with the core
// Revision 1.0
// ---------------------------------------------------------------------------
package sha256_digest_unloader_pkg;

  localparam int DIGEST_W = 256;
  localparam int DATA_W   = 64;
  localparam int WORDS    = DIGEST_W / DATA_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } unloader_state_e;

endpackage
`default_nettype wire

// File: rtl/sha256_digest_unloader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_digest_unloader_if : core-side digest handshake and host word stream
// Revision 1.0
// ---------------------------------------------------------------------------
interface sha256_digest_unloader_if #(
  parameter int DATA_W   = sha256_digest_unloader_pkg::DATA_W,
  parameter int DIGEST_W = sha256_digest_unloader_pkg::DIGEST_W
);

  logic [DIGEST_W-1:0] digest_i;
  logic                digest_valid_i;
  logic                digest_ready_o;
  logic [DATA_W-1:0]   data_o;
  logic                valid_o;
  logic                ready_i;
  logic                last_o;
  logic                drop_o;

  modport master (
    input  digest_i, digest_valid_i, ready_i,
    output digest_ready_o, data_o, valid_o, last_o, drop_o
  );

  modport slave (
    output digest_i, digest_valid_i, ready_i,
    input  digest_ready_o, data_o, valid_o, last_o, drop_o
  );

endinterface
`default_nettype wire

// File: rtl/sha256_digest_unloader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_digest_unloader : snapshots the SHA-256 digest and streams it out
// Revision 1.0
// ---------------------------------------------------------------------------
module sha256_digest_unloader #(
  parameter int DATA_W    = sha256_digest_unloader_pkg::DATA_W,
  parameter int DIGEST_W  = sha256_digest_unloader_pkg::DIGEST_W,
  parameter int MSB_FIRST = 1
) (
  input  wire logic               clk,
  input  wire logic               rst,
  sha256_digest_unloader_if.master bus
);

  import sha256_digest_unloader_pkg::*;

  localparam int N_WORDS = DIGEST_W / DATA_W;
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  unloader_state_e     state;
  logic [IDX_W-1:0]    idx;
  logic [DIGEST_W-1:0] shadow;
  logic                drop;
  logic [DATA_W-1:0]   word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      shadow <= '0;
      drop   <= 1'b0;
    end else begin
      // A digest offered while draining is never captured; flag it instead.
      drop <= (state == SEND) && bus.digest_valid_i;
      unique case (state)
        IDLE: begin
          if (bus.digest_valid_i) begin
            shadow <= bus.digest_i;
            idx    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (bus.ready_i) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    word = '0;
    for (int k = 0; k < N_WORDS; k++) begin
      if (idx == IDX_W'(k)) begin
        word = (MSB_FIRST != 0) ? shadow[DIGEST_W-1-k*DATA_W -: DATA_W]
                                : shadow[k*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.digest_ready_o = (state == IDLE);
  assign bus.valid_o        = (state == SEND);
  assign bus.data_o         = (state == SEND) ? word : '0;
  assign bus.last_o         = (state == SEND) && (idx == LAST_IDX);
  assign bus.drop_o         = drop;

endmodule
`default_nettype wire

// File: tb/tb_sha256_digest_unloader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sha256_digest_unloader : two unloaders (MSB/LSB first) against a queue model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_sha256_digest_unloader;

  localparam logic [255:0] ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] digest = '0;
  logic         dv = 1'b0;
  logic         rdy = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t qa[$];
  exp_t qb[$];
  logic exp_drop = 1'b0;
  logic [63:0] abc_words [4];

  always #5 clk = ~clk;

  sha256_digest_unloader_if #(.DATA_W(64), .DIGEST_W(256)) ifa ();
  sha256_digest_unloader_if #(.DATA_W(64), .DIGEST_W(256)) ifb ();

  assign ifa.digest_i = digest;
  assign ifa.digest_valid_i = dv;
  assign ifa.ready_i = rdy;
  assign ifb.digest_i = digest;
  assign ifb.digest_valid_i = dv;
  assign ifb.ready_i = rdy;

  sha256_digest_unloader #(.DATA_W(64), .DIGEST_W(256), .MSB_FIRST(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  sha256_digest_unloader #(.DATA_W(64), .DIGEST_W(256), .MSB_FIRST(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word k of the stream is the k-th 64-bit chunk counted from the chosen end.
  function automatic logic [63:0] word_of(input logic [255:0] d, input int k, input bit msb);
    logic [255:0] s;
    s = msb ? (d >> (64 * (3 - k))) : (d >> (64 * k));
    return s[63:0];
  endfunction

  // Reference: a busy unloader is one with words still owed to the host.
  always @(posedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      exp_drop = 1'b0;
    end else begin
      exp_drop = (qa.size() != 0) && dv;
      if (qa.size() == 0) begin
        if (dv) begin
          for (int k = 0; k < 4; k++) begin
            qa.push_back('{data: word_of(digest, k, 1'b1), last: (k == 3)});
            qb.push_back('{data: word_of(digest, k, 1'b0), last: (k == 3)});
          end
        end
      end else if (rdy) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    check("a_digest_ready", {63'd0, ifa.digest_ready_o}, {63'd0, qa.size() == 0});
    check("a_valid", {63'd0, ifa.valid_o}, {63'd0, qa.size() != 0});
    check("a_drop", {63'd0, ifa.drop_o}, {63'd0, exp_drop});
    check("b_valid", {63'd0, ifb.valid_o}, {63'd0, qb.size() != 0});
    check("b_drop", {63'd0, ifb.drop_o}, {63'd0, exp_drop});
    if (qa.size() != 0) begin
      check("a_data", ifa.data_o, qa[0].data);
      check("a_last", {63'd0, ifa.last_o}, {63'd0, qa[0].last});
      check("b_data", ifb.data_o, qb[0].data);
      check("b_last", {63'd0, ifb.last_o}, {63'd0, qb[0].last});
    end else begin
      check("a_last_idle", {63'd0, ifa.last_o}, 64'd0);
    end
  end

  // Offers d and returns at the first falling edge after it was taken.
  task automatic send_digest(input logic [255:0] d);
    int t;
    @(negedge clk);
    digest = d;
    dv = 1'b1;
    t = 0;
    while (!ifa.digest_ready_o && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!ifa.digest_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: digest_ready_o got 0 expected 1 within 40 cycles");
    end
    @(negedge clk);
    dv = 1'b0;
  endtask

  initial begin
    abc_words[0] = 64'hba7816bf8f01cfea;
    abc_words[1] = 64'h414140de5dae2223;
    abc_words[2] = 64'hb00361a396177a9c;
    abc_words[3] = 64'hb410ff61f20015ad;

    repeat (2) @(negedge clk);
    check("rst_digest_ready", {63'd0, ifa.digest_ready_o}, 64'd1);
    check("rst_valid", {63'd0, ifa.valid_o}, 64'd0);
    check("rst_last", {63'd0, ifa.last_o}, 64'd0);
    check("rst_data", ifa.data_o, 64'd0);
    check("rst_drop", {63'd0, ifa.drop_o}, 64'd0);
    rst = 1'b0;

    // "abc" at full throughput on both word orders.
    rdy = 1'b1;
    send_digest(ABC);
    for (int k = 0; k < 4; k++) begin
      check("abc_msb_word", ifa.data_o, abc_words[k]);
      check("abc_msb_last", {63'd0, ifa.last_o}, {63'd0, k == 3});
      check("abc_lsb_word", ifb.data_o, abc_words[3-k]);
      @(negedge clk);
    end
    check("abc_idle_after", {63'd0, ifa.digest_ready_o}, 64'd1);

    // Host stalls.
    rdy = 1'b0;
    send_digest(ABC);
    begin
      bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) begin
        rdy = pat[i];
        @(negedge clk);
      end
    end
    check("stall_done_idle", {63'd0, ifa.digest_ready_o}, 64'd1);

    // New digest offered while word 2 is pending.
    rdy = 1'b1;
    send_digest(ABC);
    @(negedge clk);
    @(negedge clk);
    check("drop_word2", ifa.data_o, abc_words[2]);
    dv = 1'b1;
    digest = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    dv = 1'b0;
    check("drop_pulse", {63'd0, ifa.drop_o}, 64'd1);
    check("drop_word3_kept", ifa.data_o, abc_words[3]);
    @(negedge clk);
    check("drop_pulse_end", {63'd0, ifa.drop_o}, 64'd0);

    // Reset while word 1 is stalled.
    rdy = 1'b0;
    send_digest(ABC);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
    check("rst_mid_word1", ifa.data_o, abc_words[1]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_valid", {63'd0, ifa.valid_o}, 64'd0);
    check("rst_mid_ready", {63'd0, ifa.digest_ready_o}, 64'd1);
    rdy = 1'b1;
    send_digest(ABC);
    check("rst_restart_word0", ifa.data_o, abc_words[0]);
    repeat (4) @(negedge clk);

    // Random traffic, including occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      digest = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      dv  = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 1) == 0);
      rst = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0;
    dv  = 1'b0;
    rdy = 1'b1;
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha256_digest_unloader.md
# sha256_digest_unloader

Reads the finished 256-bit SHA-256 digest from the hash core and returns it to the host as four 64-bit words over a valid/ready stream. It sits between the core's final H0..H7 state and the host read port, mirroring the 64-bit load registers on the input side. It snapshots the digest in one cycle so the core can start the next message while the words drain.

## Interface
- DATA_W, 64, output word width; must divide DIGEST_W.
- DIGEST_W, 256, digest width.
- MSB_FIRST, 1, 1: word 0 = digest[255:192] (H0,H1 first); 0: word 0 = digest[63:0].
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- digest_i  in  DIGEST_W  digest from core {H0..H7}; sampled only on accept.
- digest_valid_i  in  1  core presents a finished digest.
- digest_ready_o  out  1  unloader idle, will accept digest this cycle.
- data_o  out  DATA_W  current output word.
- valid_o  out  1  data_o valid.
- ready_i  in  1  host accepts data_o.
- last_o  out  1  high with the final word of a digest.
- drop_o  out  1  one-cycle pulse: digest_valid_i seen while busy (not accepted).

## Operation
- Derived WORDS = DIGEST_W/DATA_W (4); index counter width $clog2(WORDS).
- States: IDLE, SEND.
- IDLE: digest_ready_o=1, valid_o=0. digest_valid_i=1 -> capture digest_i into shadow register, idx<=0, go SEND.
- SEND: digest_ready_o=0, valid_o=1, data_o = shadow word idx (order per MSB_FIRST).
- Transfer = valid_o && ready_i. On transfer with idx<WORDS-1: idx<=idx+1. On transfer with idx==WORDS-1: go IDLE, idx<=0.
- last_o = SEND && idx==WORDS-1.
- digest_valid_i in SEND: ignored, drop_o pulses the following cycle; shadow unchanged.
- ready_i in IDLE: ignored.
- Core holds digest_valid_i until it sees digest_ready_o; a dropped digest is the core's responsibility.

## Timing
- Reset (RST high at edge): state IDLE, idx 0, shadow 0, drop_o 0. After that edge: digest_ready_o=1, valid_o=0, last_o=0, data_o=0.
- RST mid-SEND: pending words discarded, no further valid_o; RST overrides any simultaneous handshake.
- Accept at edge N -> valid_o=1 with word 0 in cycle after N.
- Full throughput with ready_i held high: one word per cycle, 4 words in 4 consecutive cycles.
- data_o, last_o stable while valid_o && !ready_i (no word changes without a transfer).
- After the last transfer at edge M: IDLE in cycle after M; next digest accepted no earlier than edge M+1. Minimum 5 cycles per digest.
- digest_ready_o and valid_o are decoded from the registered state only; no combinational path from ready_i or digest_valid_i to any output.

## Structure
- sha256_pkg: DIGEST_W, DATA_W, WORDS localparams, unloader state enum {IDLE, SEND}; shared with the load-side registers and the core.
- Single module, no sub-module; shadow register, counter and 2-state FSM inline.

## Test plan
- Reset: RST high 2 cycles -> digest_ready_o=1, valid_o=0, last_o=0, data_o=0.
- Digest of "abc" (ba7816bf...f20015ad), MSB_FIRST=1, ready_i=1 -> 4 consecutive words ba7816bf8f01cfea, 414140de5dae2223, b00361a396177a9c, b410ff61f20015ad; last_o only on the 4th; digest_ready_o=1 the cycle after.
- Same digest, ready_i toggling 1,0,0,1,0,1,1 -> same 4 words in order, data_o held while stalled, no duplicates.
- digest_valid_i pulsed with a new value during word 2 -> drop_o pulses once, remaining words still from the "abc" digest.
- RST asserted with valid_o=1, ready_i=0 at word 1 -> after the edge valid_o=0, digest_ready_o=1; the next digest starts again at word 0.
- MSB_FIRST=0, same digest -> first word b410ff61f20015ad, last word ba7816bf8f01cfea.
